id_ex_stage: RTL



---
 rtl/id_ex_stage_pkg.sv | 50 +++++
 rtl/id_ex_fwd_mux.sv | 38 +++
 rtl/id_ex_stage.sv | 119 +++++++++++
 3 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID/EX pipeline stage.
// ALU op codes, control bit positions, widths and the stage bundle.
package id_ex_stage_pkg;

   localparam int DATA_W  = 32;
   localparam int REG_W   = 5;
   localparam int CTRL_W  = 6;
   localparam int ALUC_W  = 4;
   localparam int SHAMT_W = 5;

   // packed control: {RegWrite, MemRead, MemWrite, MemToReg, Branch, ALUSrc}
   localparam int CTRL_REG_WRITE  = 5;
   localparam int CTRL_MEM_READ   = 4;
   localparam int CTRL_MEM_WRITE  = 3;
   localparam int CTRL_MEM_TO_REG = 2;
   localparam int CTRL_BRANCH     = 1;
   localparam int CTRL_ALU_SRC    = 0;

   typedef enum logic [ALUC_W-1:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_NOR  = 4'd5,
      ALU_SLT  = 4'd6,
      ALU_SLTU = 4'd7,
      ALU_SLL  = 4'd8,
      ALU_SRL  = 4'd9,
      ALU_SRA  = 4'd10,
      ALU_LUI  = 4'd11,
      ALU_BEQ  = 4'd12,
      ALU_BNE  = 4'd13,
      ALU_BLTZ = 4'd14
   } alu_op_e;

   typedef struct packed {
      logic               valid;
      logic [ALUC_W-1:0]  alu_op;
      logic [DATA_W-1:0]  a;
      logic [DATA_W-1:0]  b;
      logic [DATA_W-1:0]  imm;
      logic [SHAMT_W-1:0] shamt;
      logic [REG_W-1:0]   rs;
      logic [REG_W-1:0]   rt;
      logic [REG_W-1:0]   dst;
      logic [CTRL_W-1:0]  ctrl;
   } id_ex_t;

endpackage

// File: rtl/id_ex_fwd_mux.sv
// Per-operand forwarding select for the ID/EX stage (ID_EX_FORWARDING_EN).
// Ports: src index, raw reg data, EX/MEM and MEM/WB write info -> data.
`ifdef ID_EX_FORWARDING_EN
module id_ex_fwd_mux
   import id_ex_stage_pkg::*;
(
   input  logic [REG_W-1:0]  src,
   input  logic [DATA_W-1:0] raw,
   input  logic              ex_mem_we,
   input  logic [REG_W-1:0]  ex_mem_dst,
   input  logic [DATA_W-1:0] ex_mem_data,
   input  logic              mem_wb_we,
   input  logic [REG_W-1:0]  mem_wb_dst,
   input  logic [DATA_W-1:0] mem_wb_data,
   output logic [DATA_W-1:0] data
);

   logic ex_hit;
   logic wb_hit;

   // $0 is hardwired zero, so it never forwards
   assign ex_hit = ex_mem_we && (ex_mem_dst != '0)
                && (ex_mem_dst == src);
   assign wb_hit = mem_wb_we && (mem_wb_dst != '0)
                && (mem_wb_dst == src);

   // both can hit; the younger EX/MEM result wins
   always_comb begin
      data = raw;
      priority case (1'b1)
         ex_hit:  data = ex_mem_data;
         wb_hit:  data = mem_wb_data;
         default: data = raw;
      endcase
   end

endmodule
`endif

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU, with stall, flush, load-use
// hazard detect and optional operand forwarding (ID_EX_FORWARDING_EN).
// Ports: Clk/Reset, Stall/Flush, In* from ID, EX/MEM + MEM/WB fwd
// sources; Out* to ALU/EX-MEM, LoadUseHazard to hazard/PC logic.
module id_ex_stage
   import id_ex_stage_pkg::*;
(
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Stall,
   input  logic               Flush,
   input  logic               InValid,
   input  logic [ALUC_W-1:0]  InALUControl,
   input  logic [DATA_W-1:0]  InA,
   input  logic [DATA_W-1:0]  InB,
   input  logic [DATA_W-1:0]  InImm,
   input  logic [SHAMT_W-1:0] InShamt,
   input  logic [REG_W-1:0]   InRs,
   input  logic [REG_W-1:0]   InRt,
   input  logic [REG_W-1:0]   InDst,
   input  logic [CTRL_W-1:0]  InCtrl,
   input  logic               ExMemRegWrite,
   input  logic [REG_W-1:0]   ExMemDst,
   input  logic [DATA_W-1:0]  ExMemResult,
   input  logic               MemWbRegWrite,
   input  logic [REG_W-1:0]   MemWbDst,
   input  logic [DATA_W-1:0]  MemWbData,
   output logic               LoadUseHazard,
   output logic               OutValid,
   output logic [ALUC_W-1:0]  OutALUControl,
   output logic [DATA_W-1:0]  OutA,
   output logic [DATA_W-1:0]  OutB,
   output logic [SHAMT_W-1:0] OutShamt,
   output logic [DATA_W-1:0]  OutStoreData,
   output logic [REG_W-1:0]   OutDst,
   output logic [CTRL_W-1:0]  OutCtrl
);

   id_ex_t id_d;
   id_ex_t ex_q;

   logic [DATA_W-1:0] fwd_a;
   logic [DATA_W-1:0] fwd_b;

   always_comb begin
      id_d        = '0;
      id_d.valid  = InValid;
      id_d.alu_op = InALUControl;
      id_d.a      = InA;
      id_d.b      = InB;
      id_d.imm    = InImm;
      id_d.shamt  = InShamt;
      id_d.rs     = InRs;
      id_d.rt     = InRt;
      id_d.dst    = InDst;
      id_d.ctrl   = InCtrl;
   end

   // flush loads the same all-zero bubble as reset
   always_ff @(posedge Clk) begin
      if (Reset || Flush) begin
         ex_q <= '0;
      end else if (!Stall) begin
         ex_q <= id_d;
      end
   end

`ifdef ID_EX_FORWARDING_EN
   id_ex_fwd_mux u_fwd_a (
      .src         (ex_q.rs),
      .raw         (ex_q.a),
      .ex_mem_we   (ExMemRegWrite),
      .ex_mem_dst  (ExMemDst),
      .ex_mem_data (ExMemResult),
      .mem_wb_we   (MemWbRegWrite),
      .mem_wb_dst  (MemWbDst),
      .mem_wb_data (MemWbData),
      .data        (fwd_a)
   );

   id_ex_fwd_mux u_fwd_b (
      .src         (ex_q.rt),
      .raw         (ex_q.b),
      .ex_mem_we   (ExMemRegWrite),
      .ex_mem_dst  (ExMemDst),
      .ex_mem_data (ExMemResult),
      .mem_wb_we   (MemWbRegWrite),
      .mem_wb_dst  (MemWbDst),
      .mem_wb_data (MemWbData),
      .data        (fwd_b)
   );
`else
   logic unused_fwd;

   assign fwd_a = ex_q.a;
   assign fwd_b = ex_q.b;

   assign unused_fwd = ^{ExMemRegWrite, ExMemDst, ExMemResult,
                         MemWbRegWrite, MemWbDst, MemWbData,
                         ex_q.rs, ex_q.rt};
`endif

   assign OutValid      = ex_q.valid;
   assign OutALUControl = ex_q.alu_op;
   assign OutShamt      = ex_q.shamt;
   assign OutDst        = ex_q.dst;
   assign OutCtrl       = ex_q.ctrl;
   assign OutA          = fwd_a;
   assign OutB          = ex_q.ctrl[CTRL_ALU_SRC] ? ex_q.imm : fwd_b;
   assign OutStoreData  = fwd_b;

   // a load in EX whose target is read by the instruction in ID
   assign LoadUseHazard = ex_q.valid
                       && ex_q.ctrl[CTRL_MEM_READ]
                       && (ex_q.dst != '0)
                       && InValid
                       && ((ex_q.dst == InRs) || (ex_q.dst == InRt));

endmodule
